// File: rtl/fib_seq_gen_if.sv
// Control and status bundle for fib_seq_gen: the controller drives the advance/mode inputs,
// the generator returns the current term, its index and the status flags.
interface fib_seq_gen_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 8
) ();
    logic             count_t;
    logic             clear;
    logic [1:0]       mode;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] out;
    logic [IDX_W-1:0] index;
    logic             wrap;
    logic             done;
    logic             ovf;

    modport master (
        output count_t, clear, mode, limit,
        input  out, index, wrap, done, ovf
    );

    modport slave (
        input  count_t, clear, mode, limit,
        output out, index, wrap, done, ovf
    );
endinterface

// File: rtl/fib_seq_gen.sv
// Parametrised Fibonacci-style sequence generator with wrap/saturate/free-run modes.
// Every emitted term is exact: a carry out of the adder ends the run after the last exact term.
module fib_seq_gen #(
    parameter int unsigned            WIDTH = 16,
    parameter logic [WIDTH-1:0]       SEED0 = '0,
    parameter logic [WIDTH-1:0]       SEED1 = WIDTH'(1),
    parameter int unsigned            IDX_W = 8
) (
    input  logic          clock,
    input  logic          reset,
    fib_seq_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LAST = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_WRAP  = 2'd0,
        MODE_SAT   = 2'd1,
        MODE_FREE  = 2'd2,
        MODE_FREE2 = 2'd3
    } mode_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] prev_q, prev_n;
    logic [WIDTH-1:0] curr_q, curr_n;
    logic [IDX_W-1:0] index_q, index_n;
    logic             wrap_q, wrap_n;
    logic             ovf_q, ovf_n;

    logic [WIDTH:0]   sum;
    logic             carry;
    logic             at_limit;
    mode_t            mode;

    assign sum      = {1'b0, prev_q} + {1'b0, curr_q};
    assign carry    = sum[WIDTH];
    assign at_limit = (prev_q == bus.limit);
    assign mode     = mode_t'(bus.mode);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            prev_q  <= SEED0;
            curr_q  <= SEED1;
            index_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            prev_q  <= prev_n;
            curr_q  <= curr_n;
            index_q <= index_n;
            wrap_q  <= wrap_n;
            ovf_q   <= ovf_n;
        end
    end

    // Limit hits take precedence over the adder; in LAST, curr is stale and never fed back.
    always_comb begin
        state_n = state_q;
        prev_n  = prev_q;
        curr_n  = curr_q;
        index_n = index_q;
        wrap_n  = 1'b0;
        ovf_n   = ovf_q;

        if (bus.clear) begin
            state_n = RUN;
            prev_n  = SEED0;
            curr_n  = SEED1;
            index_n = '0;
            ovf_n   = 1'b0;
        end else if (bus.count_t && state_q != HOLD) begin
            if (at_limit && mode == MODE_WRAP) begin
                state_n = RUN;
                prev_n  = SEED0;
                curr_n  = SEED1;
                index_n = '0;
                wrap_n  = 1'b1;
            end else if (at_limit && mode == MODE_SAT) begin
                state_n = HOLD;
            end else if (state_q == RUN) begin
                prev_n  = curr_q;
                index_n = index_q + IDX_W'(1);
                if (carry) begin
                    ovf_n   = 1'b1;
                    state_n = LAST;
                end else begin
                    curr_n = sum[WIDTH-1:0];
                end
            end else if (mode == MODE_SAT) begin
                state_n = HOLD;
            end else begin
                state_n = RUN;
                prev_n  = SEED0;
                curr_n  = SEED1;
                index_n = '0;
                wrap_n  = 1'b1;
            end
        end
    end

    assign bus.out   = prev_q;
    assign bus.index = index_q;
    assign bus.wrap  = wrap_q;
    assign bus.done  = (state_q == HOLD);
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen: a 0/1-seeded and a Lucas-seeded 8-bit instance.
module tb_fib_seq_gen;

    typedef struct packed {
        logic [7:0] o;
        logic [7:0] idx;
        logic       w;
        logic       d;
        logic       v;
    } obs_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    obs_t got;
    obs_t want;

    always #5 clock = ~clock;

    fib_seq_gen_if #(.WIDTH(8), .IDX_W(8)) bus_a ();
    fib_seq_gen_if #(.WIDTH(8), .IDX_W(8)) bus_l ();

    fib_seq_gen #(.WIDTH(8), .SEED0(8'd0), .SEED1(8'd1), .IDX_W(8)) u_fib (
        .clock(clock),
        .reset(reset),
        .bus  (bus_a)
    );

    fib_seq_gen #(.WIDTH(8), .SEED0(8'd2), .SEED1(8'd1), .IDX_W(8)) u_luc (
        .clock(clock),
        .reset(reset),
        .bus  (bus_l)
    );

    function automatic obs_t mk(int o, int i, bit w, bit d, bit v);
        obs_t r;
        r.o = 8'(o); r.idx = 8'(i); r.w = w; r.d = d; r.v = v;
        return r;
    endfunction

    function automatic obs_t obs_a();
        obs_t r;
        r.o = bus_a.out; r.idx = bus_a.index; r.w = bus_a.wrap; r.d = bus_a.done; r.v = bus_a.ovf;
        return r;
    endfunction

    function automatic obs_t obs_l();
        obs_t r;
        r.o = bus_l.out; r.idx = bus_l.index; r.w = bus_l.wrap; r.d = bus_l.done; r.v = bus_l.ovf;
        return r;
    endfunction

    function automatic string fmt(obs_t x);
        return $sformatf("out=%0d idx=%0d wrap=%b done=%b ovf=%b", x.o, x.idx, x.w, x.d, x.v);
    endfunction

    task automatic drive_a(input logic ct, input logic clr);
        bus_a.count_t = ct;
        bus_a.clear   = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_l(input logic ct, input logic clr);
        bus_l.count_t = ct;
        bus_l.clear   = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bus_a.count_t = 0; bus_a.clear = 0; bus_a.mode = 2'd0; bus_a.limit = 8'd34;
        bus_l.count_t = 0; bus_l.clear = 0; bus_l.mode = 2'd0; bus_l.limit = 8'd11;
        reset = 1'b1;
        #12;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        got = obs_a(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL reset_fib got %s want %s", fmt(got), fmt(want)); end
        exp_q.push_back(mk(2, 0, 0, 0, 0));
        got = obs_l(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL reset_lucas got %s want %s", fmt(got), fmt(want)); end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_sequence();
        int seq[11] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 0, 1};
        int idx[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
        bus_a.mode = 2'd0; bus_a.limit = 8'd34;
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(mk(seq[i], idx[i], (i == 9), 0, 0));
            drive_a(1'b1, 1'b0);
            got = obs_a(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL wrap_seq step %0d got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_enable();
        logic ct[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   idx[4] = '{1, 1, 1, 2};
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        drive_a(1'b1, 1'b1);
        got = obs_a(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL clear_over_count got %s want %s", fmt(got), fmt(want)); end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(1, idx[i], 0, 0, 0));
            drive_a(ct[i], 1'b0);
            got = obs_a(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL enable step %0d got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_overflow();
        int seq[15] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 0, 1};
        int idx[15] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 0, 1};
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        drive_a(1'b1, 1'b1);
        got = obs_a(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL ovf_clear got %s want %s", fmt(got), fmt(want)); end
        for (int i = 0; i < 15; i++) begin
            bus_a.mode = (i < 6) ? 2'd2 : 2'd3;
            exp_q.push_back(mk(seq[i], idx[i], (i == 13), 0, (i >= 12)));
            drive_a(1'b1, 1'b0);
            got = obs_a(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL overflow step %0d got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_async_reset();
        int seq[6] = '{1, 2, 3, 5, 8, 13};
        int res[3] = '{1, 1, 2};
        bus_a.mode = 2'd0; bus_a.limit = 8'd34;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(mk(seq[i], i + 2, 0, 0, 1));
            drive_a(1'b1, 1'b0);
            got = obs_a(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL pre_reset step %0d got %s want %s", i, fmt(got), fmt(want)); end
        end
        #2 reset = 1'b1;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        got = obs_a(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL async_reset got %s want %s", fmt(got), fmt(want)); end
        bus_a.count_t = 1'b0;
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(res[i], i + 1, 0, 0, 0));
            drive_a(1'b1, 1'b0);
            got = obs_a(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL resume step %0d got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    task automatic test_saturate();
        int seq[8] = '{1, 1, 2, 3, 5, 8, 13, 21};
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        drive_a(1'b1, 1'b1);
        got = obs_a(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL sat_clear got %s want %s", fmt(got), fmt(want)); end
        bus_a.mode = 2'd1; bus_a.limit = 8'd21;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(seq[i], i + 1, 0, 0, 0));
            drive_a(1'b1, 1'b0);
            got = obs_a(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL sat_run step %0d got %s want %s", i, fmt(got), fmt(want)); end
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 2) bus_a.mode = 2'd0;
            if (i == 4) bus_a.limit = 8'd99;
            exp_q.push_back(mk(21, 8, 0, 1, 0));
            drive_a(1'b1, 1'b0);
            got = obs_a(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL sat_hold step %0d got %s want %s", i, fmt(got), fmt(want)); end
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        drive_a(1'b1, 1'b1);
        got = obs_a(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL sat_release got %s want %s", fmt(got), fmt(want)); end
    endtask

    task automatic test_live_limit();
        int seq[5] = '{1, 1, 2, 3, 5};
        bus_a.mode = 2'd0; bus_a.limit = 8'd200;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mk(seq[i], i + 1, 0, 0, 0));
            drive_a(1'b1, 1'b0);
            got = obs_a(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL live_run step %0d got %s want %s", i, fmt(got), fmt(want)); end
        end
        bus_a.limit = 8'd5;
        exp_q.push_back(mk(0, 0, 1, 0, 0));
        drive_a(1'b1, 1'b0);
        got = obs_a(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL live_limit_wrap got %s want %s", fmt(got), fmt(want)); end
        exp_q.push_back(mk(1, 1, 0, 0, 0));
        drive_a(1'b1, 1'b0);
        got = obs_a(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL live_after_wrap got %s want %s", fmt(got), fmt(want)); end
    endtask

    task automatic test_lucas();
        int seq[7] = '{1, 3, 4, 7, 11, 2, 1};
        int idx[7] = '{1, 2, 3, 4, 5, 0, 1};
        bus_l.mode = 2'd0; bus_l.limit = 8'd11;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(mk(seq[i], idx[i], (i == 5), 0, 0));
            drive_l(1'b1, 1'b0);
            got = obs_l(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL lucas step %0d got %s want %s", i, fmt(got), fmt(want)); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequence();
        test_enable();
        test_overflow();
        test_async_reset();
        test_saturate();
        test_live_limit();
        test_lucas();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
